// File: rtl/ahb_timer_pkg.sv
// Shared register map, FSM encoding and helpers for the AHB timer scheduler.
// Offsets are AHB word offsets (HADDR[7:2]).
package ahb_timer_pkg;

  localparam logic [5:0] OFF_CTRL      = 6'h00;
  localparam logic [5:0] OFF_STATUS    = 6'h01;
  localparam logic [5:0] OFF_IRQ_ID    = 6'h02;
  localparam logic [5:0] OFF_TICK      = 6'h03;
  // RELOAD_i at 0x10+4i and COUNT_i at 0x20+4i: selected by HADDR[7:4], channel in HADDR[3:2]
  localparam logic [3:0] BLK_RELOAD    = 4'h1;
  localparam logic [3:0] BLK_COUNT     = 4'h2;

  localparam int         IRQ_VLD_BIT   = 31;
  localparam int         OS_LSB        = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  function automatic logic [1:0] rr_next(input logic [1:0] id, input int nch);
    return (int'(id) == nch - 1) ? 2'd0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/ahb_timer_rr_pick.sv
// Combinational cyclic priority picker: first set pending bit at or after the pointer.
// Zero latency; no handshake.
module ahb_timer_rr_pick
  import ahb_timer_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] i_pend,
  input  logic [1:0]     i_rr_ptr,
  output logic           o_vld,
  output logic [1:0]     o_id
);

  logic [2:0] w_sum;

  // Walk from farthest to nearest so the channel closest to the pointer wins.
  always_comb begin
    o_vld = 1'b0;
    o_id  = 2'd0;
    w_sum = 3'd0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_rr_ptr} + 3'(k);
      if (w_sum >= 3'(NCH)) begin
        w_sum = w_sum - 3'(NCH);
      end
      if (i_pend[w_sum[1:0]]) begin
        o_vld = 1'b1;
        o_id  = w_sum[1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_timer_sched.sv
// AHB-Lite multi-channel software timer: shared prescaler, one-channel-per-cycle decrement scan, RR IRQ pick.
// Zero wait states (HREADYOUT tied high); TIMER_ONESHOT_EN enables per-channel oneshot mode.
module ahb_timer_sched
  import ahb_timer_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int PRESCALE = 16,
  parameter int CNT_W    = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HSEL,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        timer_irq
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Bus address-phase latch
  logic [5:0]       r_addr;
  logic             r_wr;

  // Timebase and scan FSM
  logic [PRE_W-1:0] r_pre_cnt;
  logic [31:0]      r_tick_cnt;
  logic             w_tick;
  state_e           r_state, w_state_nxt;
  logic [1:0]       r_scan_ch, w_scan_nxt;

  // Channel state
  logic [NCH-1:0]   r_en, w_en_nxt;
  logic [NCH-1:0]   r_pend, w_pend_set, w_pend_clr;
  logic [1:0]       r_rr_ptr;
  logic [CNT_W-1:0] r_reload [NCH];
  logic [CNT_W-1:0] r_count  [NCH];
  logic [CNT_W-1:0] w_rel_nxt [NCH];
  logic [CNT_W-1:0] w_cnt_nxt [NCH];
`ifdef TIMER_ONESHOT_EN
  logic [NCH-1:0]   r_os, w_os_nxt;
`endif

  logic             w_pick_vld;
  logic [1:0]       w_pick_id;
  logic             w_ch_ok;
  logic             w_wr_ctrl, w_wr_status, w_wr_reload;
  logic             w_unused;

  assign HREADYOUT   = 1'b1;
  assign timer_irq   = |r_pend;
  assign w_tick      = (r_pre_cnt == PRE_W'(PRESCALE - 1));
  assign w_ch_ok     = int'(r_addr[1:0]) < NCH;
  assign w_wr_ctrl   = r_wr && (r_addr == OFF_CTRL);
  assign w_wr_status = r_wr && (r_addr == OFF_STATUS);
  assign w_wr_reload = r_wr && (r_addr[5:2] == BLK_RELOAD) && w_ch_ok;
  assign w_unused    = ^{HADDR[31:8], HADDR[1:0], HTRANS[0], HWDATA};

  ahb_timer_rr_pick #(.NCH(NCH)) u_pick (
    .i_pend   (r_pend),
    .i_rr_ptr (r_rr_ptr),
    .o_vld    (w_pick_vld),
    .o_id     (w_pick_id)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_addr <= '0;
      r_wr   <= 1'b0;
    end else if (HREADY) begin
      r_addr <= HADDR[7:2];
      r_wr   <= HSEL && HTRANS[1] && HWRITE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state   <= ST_IDLE;
      r_scan_ch <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_scan_ch <= w_scan_nxt;
    end
  end

  // PRESCALE >= NCH+1 guarantees a scan finishes before the next tick.
  always_comb begin
    w_state_nxt = r_state;
    w_scan_nxt  = r_scan_ch;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          w_state_nxt = ST_SCAN;
          w_scan_nxt  = 2'd0;
        end
      end
      ST_SCAN: begin
        if (int'(r_scan_ch) == NCH - 1) begin
          w_state_nxt = ST_IDLE;
          w_scan_nxt  = 2'd0;
        end else begin
          w_scan_nxt  = r_scan_ch + 2'd1;
        end
      end
    endcase
  end

  // Scan update first, bus writes after so a software load overrides the same-cycle decrement.
  always_comb begin
    w_en_nxt   = r_en;
    w_pend_set = '0;
    w_pend_clr = '0;
`ifdef TIMER_ONESHOT_EN
    w_os_nxt   = r_os;
`endif
    for (int c = 0; c < NCH; c++) begin
      w_rel_nxt[c] = r_reload[c];
      w_cnt_nxt[c] = r_count[c];
    end

    if (r_state == ST_SCAN) begin
      for (int c = 0; c < NCH; c++) begin
        if (r_scan_ch == 2'(c) && r_en[c] && (r_reload[c] != '0)) begin
          if (r_count[c] == CNT_W'(1)) begin
            w_cnt_nxt[c]  = r_reload[c];
            w_pend_set[c] = 1'b1;
`ifdef TIMER_ONESHOT_EN
            if (r_os[c]) begin
              w_en_nxt[c] = 1'b0;
            end
`endif
          end else if (r_count[c] == '0) begin
            w_cnt_nxt[c] = r_reload[c] - CNT_W'(1);
          end else begin
            w_cnt_nxt[c] = r_count[c] - CNT_W'(1);
          end
        end
      end
    end

    if (w_wr_ctrl) begin
      w_en_nxt = HWDATA[NCH-1:0];
`ifdef TIMER_ONESHOT_EN
      w_os_nxt = HWDATA[OS_LSB +: NCH];
`endif
      for (int c = 0; c < NCH; c++) begin
        if (HWDATA[c] && !r_en[c]) begin
          w_cnt_nxt[c] = r_reload[c];
        end
      end
    end

    if (w_wr_status) begin
      w_pend_clr = HWDATA[NCH-1:0];
    end

    if (w_wr_reload) begin
      for (int c = 0; c < NCH; c++) begin
        if (r_addr[1:0] == 2'(c)) begin
          w_rel_nxt[c] = HWDATA[CNT_W-1:0];
          w_cnt_nxt[c] = HWDATA[CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pre_cnt  <= '0;
      r_tick_cnt <= '0;
      r_en       <= '0;
      r_pend     <= '0;
      r_rr_ptr   <= 2'd0;
`ifdef TIMER_ONESHOT_EN
      r_os       <= '0;
`endif
      for (int c = 0; c < NCH; c++) begin
        r_reload[c] <= '0;
        r_count[c]  <= '0;
      end
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
      if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + 32'd1;
      end
      r_en   <= w_en_nxt;
      r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
`ifdef TIMER_ONESHOT_EN
      r_os   <= w_os_nxt;
`endif
      if (w_wr_status && w_pick_vld && HWDATA[w_pick_id]) begin
        r_rr_ptr <= rr_next(w_pick_id, NCH);
      end
      for (int c = 0; c < NCH; c++) begin
        r_reload[c] <= w_rel_nxt[c];
        r_count[c]  <= w_cnt_nxt[c];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (r_addr == OFF_CTRL) begin
      HRDATA[NCH-1:0] = r_en;
`ifdef TIMER_ONESHOT_EN
      HRDATA[OS_LSB +: NCH] = r_os;
`endif
    end else if (r_addr == OFF_STATUS) begin
      HRDATA[NCH-1:0] = r_pend;
    end else if (r_addr == OFF_IRQ_ID) begin
      HRDATA[IRQ_VLD_BIT] = w_pick_vld;
      HRDATA[1:0]         = w_pick_id;
    end else if (r_addr == OFF_TICK) begin
      HRDATA = r_tick_cnt;
    end else if (r_addr[5:2] == BLK_RELOAD && w_ch_ok) begin
      HRDATA[CNT_W-1:0] = r_reload[r_addr[1:0]];
    end else if (r_addr[5:2] == BLK_COUNT && w_ch_ok) begin
      HRDATA[CNT_W-1:0] = r_count[r_addr[1:0]];
    end
  end

endmodule
